assert_checker: RTL and testbench

ASSERT_CHECKER -- requirements
Module: assert_checker

---
 rtl/assert_checker_pkg.sv | 33 +++
 rtl/assert_checker_i2c_bus_mon.sv | 38 +++
 rtl/assert_checker.sv | 111 +++++++++++
 tb/tb_assert_checker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/assert_checker_pkg.sv
// assert_checker_pkg: register map, command codes, error bit indices and helpers
package assert_checker_pkg;
  localparam int unsigned ADR_CSR = 0;
  localparam int unsigned ADR_DPR = 1;
  localparam int unsigned ADR_CMDR = 2;
  localparam int unsigned ADR_FSMR = 3;
  typedef enum logic [2:0] {
    CMD_WAIT     = 3'b000,
    CMD_WRITE    = 3'b001,
    CMD_READ_ACK = 3'b010,
    CMD_READ_NAK = 3'b011,
    CMD_START    = 3'b100,
    CMD_STOP     = 3'b101,
    CMD_SET_BUS  = 3'b110,
    CMD_RSVD     = 3'b111
  } cmd_e;
  localparam int ERR_WB_ACK_NO_STB = 0;
  localparam int ERR_WB_UNSTABLE = 1;
  localparam int ERR_WB_FSMR_WR = 2;
  localparam int ERR_WB_BAD_CMD = 3;
  localparam int ERR_IRQ_NOT_EN = 4;
  localparam int ERR_I2C_STOP_IDLE = 5;
  localparam int ERR_I2C_FRAME = 6;
  localparam int ERR_I2C_MULTI_BUSY = 7;
  localparam int ERR_W = 8;
  localparam int CSR_IE = 6;
  localparam int CNT_W = 16;
  localparam int BIT_CNT_W = 4;
  function automatic logic [3:0] popcount8(input logic [ERR_W-1:0] v);
    popcount8 = '0;
    for (int i = 0; i < ERR_W; i++) popcount8 = popcount8 + 4'(v[i]);
  endfunction
endpackage

// File: rtl/assert_checker_i2c_bus_mon.sv
// i2c_bus_mon: START/STOP detection, busy flag and bit counter for one I2C bus
module i2c_bus_mon
  import assert_checker_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scl,
  input  logic                 sda,
  output logic                 start,
  output logic                 stop,
  output logic                 busy,
  output logic [BIT_CNT_W-1:0] bit_cnt
);
  logic scl_q, sda_q, busy_q, busy_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  // Condition detect; the counter runs 1..9 so the STOP clock edge after byte+ACK lands on 1
  always_comb begin
    start = scl_q & scl & sda_q & ~sda;
    stop = scl_q & scl & ~sda_q & sda;
    busy_d = start | (busy_q & ~stop);
    cnt_d = start ? '0 : (~scl_q & scl & busy_q) ? ((cnt_q == 4'd9) ? 4'd1 : cnt_q + 4'd1) : cnt_q;
  end
  // Previous line samples idle high; transfer state clears on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
      busy_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
    end
  assign busy = busy_q;
  assign bit_cnt = cnt_q;
endmodule

// File: rtl/assert_checker.sv
// assert_checker: passive protocol checker for a Wishbone-attached I2C controller
module assert_checker
  import assert_checker_pkg::*;
#(
  parameter int NUM_I2C_BUSSES = 1,
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      irq_i,
  input  logic                      cyc_o,
  input  logic                      stb_o,
  input  logic                      we_o,
  input  logic                      ack_i,
  input  logic [WB_ADDR_WIDTH-1:0]  adr_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic [NUM_I2C_BUSSES-1:0] scl_i,
  input  logic [NUM_I2C_BUSSES-1:0] sda_i,
  output logic [ERR_W-1:0]          err_pulse_o,
  output logic [ERR_W-1:0]          err_sticky_o,
  output logic [CNT_W-1:0]          err_cnt_o,
  output logic [NUM_I2C_BUSSES-1:0] busy_o
);
  logic [NUM_I2C_BUSSES-1:0] start, stop, busy, oth;
  logic [BIT_CNT_W-1:0] bit_cnt [NUM_I2C_BUSSES];
  logic vld, wr_ack, stop_idle, frame, multi;
  logic armed_q, armed_d, pend_q, pend_d, we_q, we_d, ie_q, ie_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [ERR_W-1:0] err_raw, err_q, err_d, sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0] cnt_sum;
  logic unused_dat_i;
  assign unused_dat_i = ^dat_i;
  for (genvar b = 0; b < NUM_I2C_BUSSES; b++) begin : g_bus
    i2c_bus_mon u_mon (
      .clk(clk_i),
      .rst_n(rst_i),
      .scl(scl_i[b]),
      .sda(sda_i[b]),
      .start(start[b]),
      .stop(stop[b]),
      .busy(busy[b]),
      .bit_cnt(bit_cnt[b])
    );
  end
  // Rule evaluation on the current sample; suppressed on the first sample after reset release
  always_comb begin
    vld = cyc_o & stb_o;
    wr_ack = vld & we_o & ack_i;
    stop_idle = 1'b0;
    frame = 1'b0;
    multi = 1'b0;
    oth = '0;
    for (int k = 0; k < NUM_I2C_BUSSES; k++) begin
      oth = busy;
      oth[k] = 1'b0;
      stop_idle = stop_idle | (stop[k] & ~busy[k]);
      frame = frame | ((stop[k] | (start[k] & busy[k])) & (bit_cnt[k] > 4'd1));
      multi = multi | (start[k] & |oth);
    end
    err_raw = '0;
    err_raw[ERR_WB_ACK_NO_STB] = ack_i & ~vld;
    err_raw[ERR_WB_UNSTABLE] = pend_q & vld & ((adr_o != adr_q) | (we_o != we_q) | (we_o & (dat_o != dat_q)));
    err_raw[ERR_WB_FSMR_WR] = wr_ack & (adr_o == WB_ADDR_WIDTH'(ADR_FSMR));
    err_raw[ERR_WB_BAD_CMD] = wr_ack & (adr_o == WB_ADDR_WIDTH'(ADR_CMDR)) & (dat_o[2:0] == CMD_RSVD);
    err_raw[ERR_IRQ_NOT_EN] = irq_i & ~ie_q;
    err_raw[ERR_I2C_STOP_IDLE] = stop_idle;
    err_raw[ERR_I2C_FRAME] = frame;
    err_raw[ERR_I2C_MULTI_BUSY] = multi;
    err_d = armed_q ? err_raw : '0;
    sticky_d = sticky_q | err_d;
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(popcount8(err_d));
    cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    ie_d = (wr_ack & (adr_o == WB_ADDR_WIDTH'(ADR_CSR))) ? dat_o[CSR_IE] : ie_q;
    pend_d = vld & ~ack_i;
    adr_d = adr_o;
    we_d = we_o;
    dat_d = dat_o;
    armed_d = 1'b1;
  end
  // Error outputs and Wishbone history registers
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      armed_q <= 1'b0;
      pend_q <= 1'b0;
      we_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      ie_q <= 1'b0;
      err_q <= '0;
      sticky_q <= '0;
      cnt_q <= '0;
    end else begin
      armed_q <= armed_d;
      pend_q <= pend_d;
      we_q <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      ie_q <= ie_d;
      err_q <= err_d;
      sticky_q <= sticky_d;
      cnt_q <= cnt_d;
    end
  assign err_pulse_o = err_q;
  assign err_sticky_o = sticky_q;
  assign err_cnt_o = cnt_q;
  assign busy_o = busy;
endmodule

// File: tb/tb_assert_checker.sv
// tb_assert_checker: scoreboard-based self-checking bench for assert_checker
module tb_assert_checker;
  localparam int NB = 2;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic irq_i = 1'b0, cyc_o = 1'b0, stb_o = 1'b0, we_o = 1'b0, ack_i = 1'b0;
  logic [1:0] adr_o = '0;
  logic [7:0] dat_o = '0, dat_i = '0;
  logic [NB-1:0] scl_i = '1, sda_i = '1;
  logic [7:0] err_pulse_o, err_sticky_o;
  logic [15:0] err_cnt_o;
  logic [NB-1:0] busy_o;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  logic [7:0] exp_sticky = '0;
  int exp_cnt = 0;
  int checks = 0;
  int errors = 0;

  assert_checker #(.NUM_I2C_BUSSES(NB), .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_i(irq_i), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .ack_i(ack_i), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .scl_i(scl_i), .sda_i(sda_i),
    .err_pulse_o(err_pulse_o), .err_sticky_o(err_sticky_o), .err_cnt_o(err_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: each driven sample queues the pulse it must produce one clock later
  always @(posedge clk_i) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      checks++;
      if (err_pulse_o !== mon_exp) begin
        errors++;
        $display("FAIL err_pulse at %0t: got %h expected %h", $time, err_pulse_o, mon_exp);
      end
    end
  end

  task automatic drive(input logic [7:0] exp);
    exp_q.push_back(exp);
    exp_cnt += $countones(exp);
    exp_sticky |= exp;
    @(posedge clk_i);
    #2;
  endtask

  task automatic wb(input logic c, input logic s, input logic w, input logic a,
                    input logic [1:0] ad, input logic [7:0] d);
    cyc_o = c; stb_o = s; we_o = w; ack_i = a; adr_o = ad; dat_o = d;
  endtask

  task automatic i2c_start(input int b, input logic [7:0] exp);
    sda_i[b] = 1'b1; drive(8'h00);
    scl_i[b] = 1'b1; drive(8'h00);
    sda_i[b] = 1'b0; drive(exp);
    scl_i[b] = 1'b0; drive(8'h00);
  endtask

  task automatic i2c_bit(input int b);
    scl_i[b] = 1'b1; drive(8'h00);
    scl_i[b] = 1'b0; drive(8'h00);
  endtask

  task automatic i2c_stop(input int b, input logic [7:0] exp);
    scl_i[b] = 1'b0; drive(8'h00);
    sda_i[b] = 1'b0; drive(8'h00);
    scl_i[b] = 1'b1; drive(8'h00);
    sda_i[b] = 1'b1; drive(exp);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #2;
    checks++; if (err_pulse_o !== 8'h00) begin errors++; $display("FAIL reset_pulse: got %h expected 00", err_pulse_o); end
    checks++; if (err_sticky_o !== 8'h00) begin errors++; $display("FAIL reset_sticky: got %h expected 00", err_sticky_o); end
    checks++; if (err_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", err_cnt_o); end
    checks++; if (busy_o !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", busy_o); end
    ack_i = 1'b1;
    rst_i = 1'b1;
    exp_cnt = 0; exp_sticky = '0;
    drive(8'h00);
    drive(8'h01);
    ack_i = 1'b0;
    drive(8'h00);
  endtask

  task automatic test_ack_no_stb();
    wb(1, 0, 0, 1, 2'd0, 8'h00); drive(8'h01);
    wb(0, 0, 0, 0, 2'd0, 8'h00); drive(8'h00);
    checks++; if (err_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL ack_cnt: got %0d expected %0d", err_cnt_o, exp_cnt); end
    checks++; if (err_sticky_o !== exp_sticky) begin errors++; $display("FAIL ack_sticky: got %h expected %h", err_sticky_o, exp_sticky); end
  endtask

  task automatic test_wb_cmd();
    wb(1, 1, 1, 1, 2'd2, 8'h07); drive(8'h08);
    wb(1, 1, 1, 1, 2'd2, 8'h04); drive(8'h00);
    wb(1, 1, 1, 1, 2'd3, 8'h00); drive(8'h04);
    wb(1, 1, 1, 0, 2'd1, 8'h11); drive(8'h00);
    wb(1, 1, 1, 0, 2'd1, 8'h12); drive(8'h02);
    wb(1, 1, 1, 1, 2'd1, 8'h12); drive(8'h00);
    wb(1, 1, 0, 0, 2'd0, 8'h33); drive(8'h00);
    wb(1, 1, 0, 1, 2'd0, 8'h44); drive(8'h00);
    wb(0, 0, 0, 0, 2'd0, 8'h00); drive(8'h00);
    checks++; if (err_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL wb_cnt: got %0d expected %0d", err_cnt_o, exp_cnt); end
  endtask

  task automatic test_multi_rule();
    wb(1, 1, 1, 0, 2'd2, 8'h04); drive(8'h00);
    irq_i = 1'b1;
    wb(1, 1, 1, 1, 2'd3, 8'h04); drive(8'h16);
    irq_i = 1'b0;
    wb(0, 0, 0, 0, 2'd0, 8'h00); drive(8'h00);
    checks++; if (err_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL multi_cnt: got %0d expected %0d", err_cnt_o, exp_cnt); end
  endtask

  task automatic test_irq();
    wb(1, 1, 1, 1, 2'd0, 8'h80); drive(8'h00);
    wb(0, 0, 0, 0, 2'd0, 8'h00);
    irq_i = 1'b1; drive(8'h10);
    irq_i = 1'b0;
    wb(1, 1, 1, 1, 2'd0, 8'hC0); drive(8'h00);
    wb(0, 0, 0, 0, 2'd0, 8'h00);
    irq_i = 1'b1; drive(8'h00);
    wb(1, 1, 1, 1, 2'd0, 8'h00); drive(8'h00);
    wb(0, 0, 0, 0, 2'd0, 8'h00); drive(8'h10);
    irq_i = 1'b0; drive(8'h00);
    checks++; if (err_sticky_o !== exp_sticky) begin errors++; $display("FAIL irq_sticky: got %h expected %h", err_sticky_o, exp_sticky); end
  endtask

  task automatic test_i2c_frame_err();
    i2c_start(0, 8'h00);
    repeat (4) i2c_bit(0);
    i2c_stop(0, 8'h40);
    checks++; if (busy_o !== 2'b00) begin errors++; $display("FAIL frame_err_busy: got %b expected 00", busy_o); end
  endtask

  task automatic test_i2c_frame_ok();
    i2c_start(0, 8'h00);
    checks++; if (busy_o !== 2'b01) begin errors++; $display("FAIL frame_ok_busy_set: got %b expected 01", busy_o); end
    repeat (9) i2c_bit(0);
    i2c_stop(0, 8'h00);
    checks++; if (busy_o !== 2'b00) begin errors++; $display("FAIL frame_ok_busy_clr: got %b expected 00", busy_o); end
  endtask

  task automatic test_stop_idle();
    i2c_stop(0, 8'h20);
    checks++; if (err_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL stop_idle_cnt: got %0d expected %0d", err_cnt_o, exp_cnt); end
  endtask

  task automatic test_multi_busy_reset();
    i2c_start(0, 8'h00);
    i2c_start(1, 8'h80);
    checks++; if (busy_o !== 2'b11) begin errors++; $display("FAIL multi_busy: got %b expected 11", busy_o); end
    checks++; if (err_sticky_o !== exp_sticky) begin errors++; $display("FAIL final_sticky: got %h expected %h", err_sticky_o, exp_sticky); end
    i2c_bit(0);
    rst_i = 1'b0;
    #1;
    checks++; if (err_pulse_o !== 8'h00) begin errors++; $display("FAIL midreset_pulse: got %h expected 00", err_pulse_o); end
    checks++; if (err_sticky_o !== 8'h00) begin errors++; $display("FAIL midreset_sticky: got %h expected 00", err_sticky_o); end
    checks++; if (err_cnt_o !== 16'h0) begin errors++; $display("FAIL midreset_cnt: got %h expected 0", err_cnt_o); end
    checks++; if (busy_o !== 2'b00) begin errors++; $display("FAIL midreset_busy: got %b expected 00", busy_o); end
    scl_i = '1; sda_i = '1;
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    exp_cnt = 0; exp_sticky = '0;
    drive(8'h00);
    drive(8'h00);
    checks++; if (busy_o !== 2'b00) begin errors++; $display("FAIL post_reset_busy: got %b expected 00", busy_o); end
    checks++; if (err_cnt_o !== 16'h0) begin errors++; $display("FAIL post_reset_cnt: got %h expected 0", err_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_ack_no_stb();
    test_wb_cmd();
    test_multi_rule();
    test_irq();
    test_i2c_frame_err();
    test_i2c_frame_ok();
    test_stop_idle();
    test_multi_busy_reset();
    repeat (2) @(posedge clk_i);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
